// File: rtl/attn_row_sequencer.sv
// Control FSM for the attention score datapath: sequences operand loads, MAC,
// e^x capture, row-sum pass and credit-gated per-column output of one row.
module attn_row_sequencer #(
    parameter  int N_FEAT  = 4,
    parameter  int N_COL   = 4,
    parameter  int CREDITS = 2,
    localparam int CW      = $clog2(N_COL),
    localparam int FW      = $clog2(N_FEAT),
    localparam int KW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          s_vld,
    output logic          s_rdy,
    output logic          a_ld,
    output logic          b_ld,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          ex_cap,
    output logic [CW-1:0] ex_idx,
    output logic          sum_en,
    output logic          sum_clr,
    output logic [CW-1:0] sum_idx,
    output logic          m_vld,
    output logic [CW-1:0] m_idx,
    output logic          m_last,
    input  logic          credit_ret,
    output logic          row_done,
    output logic          busy,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_A,
        S_LD_B,
        S_MAC,
        S_EXCAP,
        S_SUM,
        S_EMIT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [FW-1:0] r_feat_cnt;
    logic [FW-1:0] w_feat_nxt;
    logic [CW-1:0] r_col_cnt;
    logic [CW-1:0] w_col_nxt;
    logic [CW-1:0] r_sum_cnt;
    logic [CW-1:0] w_sum_nxt;
    logic [CW-1:0] r_emit_cnt;
    logic [CW-1:0] w_emit_nxt;
    logic [KW-1:0] r_credits;
    logic [KW-1:0] w_cred_nxt;
    logic          r_err;
    logic          r_row_done;
    logic          w_row_end;
    logic          w_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_feat_cnt <= '0;
            r_col_cnt  <= '0;
            r_sum_cnt  <= '0;
            r_emit_cnt <= '0;
            r_credits  <= KW'(CREDITS);
            r_err      <= 1'b0;
            r_row_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_feat_cnt <= w_feat_nxt;
            r_col_cnt  <= w_col_nxt;
            r_sum_cnt  <= w_sum_nxt;
            r_emit_cnt <= w_emit_nxt;
            r_credits  <= w_cred_nxt;
            r_err      <= r_err | w_ovf;
            r_row_done <= w_row_end;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_feat_nxt  = r_feat_cnt;
        w_col_nxt   = r_col_cnt;
        w_sum_nxt   = r_sum_cnt;
        w_emit_nxt  = r_emit_cnt;
        w_row_end   = 1'b0;
        s_rdy       = 1'b0;
        a_ld        = 1'b0;
        b_ld        = 1'b0;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        ex_cap      = 1'b0;
        sum_en      = 1'b0;
        sum_clr     = 1'b0;
        m_vld       = 1'b0;
        m_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_LD_A;
            end
            S_LD_A: begin
                s_rdy = 1'b1;
                if (s_vld) begin
                    a_ld        = 1'b1;
                    w_state_nxt = S_LD_B;
                end
            end
            S_LD_B: begin
                s_rdy = 1'b1;
                if (s_vld) begin
                    b_ld        = 1'b1;
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                mac_en  = 1'b1;
                mac_clr = (r_feat_cnt == '0);
                if (r_feat_cnt == FW'(N_FEAT - 1)) begin
                    w_feat_nxt  = '0;
                    w_state_nxt = S_EXCAP;
                end else begin
                    w_feat_nxt  = r_feat_cnt + 1'b1;
                    w_state_nxt = S_LD_A;
                end
            end
            S_EXCAP: begin
                ex_cap = 1'b1;
                if (r_col_cnt == CW'(N_COL - 1)) begin
                    w_col_nxt   = '0;
                    w_state_nxt = S_SUM;
                end else begin
                    w_col_nxt   = r_col_cnt + 1'b1;
                    w_state_nxt = S_LD_A;
                end
            end
            S_SUM: begin
                sum_en  = 1'b1;
                sum_clr = (r_sum_cnt == '0);
                if (r_sum_cnt == CW'(N_COL - 1)) begin
                    w_sum_nxt   = '0;
                    w_state_nxt = S_EMIT;
                end else begin
                    w_sum_nxt   = r_sum_cnt + 1'b1;
                end
            end
            S_EMIT: begin
                // With no credits everything holds; the beat counter only moves on a beat.
                if (r_credits != '0) begin
                    m_vld  = 1'b1;
                    m_last = (r_emit_cnt == CW'(N_COL - 1));
                    if (m_last) begin
                        w_emit_nxt  = '0;
                        w_row_end   = 1'b1;
                        w_state_nxt = en ? S_LD_A : S_IDLE;
                    end else begin
                        w_emit_nxt  = r_emit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A return with the pool full and nothing consumed is an overflow: count held, err latched.
    always_comb begin
        w_cred_nxt = r_credits;
        w_ovf      = 1'b0;
        if (m_vld && !credit_ret) begin
            w_cred_nxt = r_credits - 1'b1;
        end else if (!m_vld && credit_ret) begin
            if (r_credits == KW'(CREDITS)) w_ovf = 1'b1;
            else                           w_cred_nxt = r_credits + 1'b1;
        end
    end

    assign ex_idx   = r_col_cnt;
    assign sum_idx  = r_sum_cnt;
    assign m_idx    = r_emit_cnt;
    assign row_done = r_row_done;
    assign busy     = (r_state != S_IDLE);
    assign err      = r_err;

endmodule

// File: tb/tb_attn_row_sequencer.sv
// Scoreboard bench for attn_row_sequencer: per-row expected strobe values are
// queued up front and popped as the DUT issues each strobe.
module tb_attn_row_sequencer;

    localparam int N_FEAT  = 4;
    localparam int N_COL   = 4;
    localparam int CREDITS = 2;
    localparam int CW      = $clog2(N_COL);

    logic          clk = 1'b0;
    logic          rst_n, en, s_vld, credit_ret;
    logic          s_rdy, a_ld, b_ld, mac_en, mac_clr, ex_cap;
    logic          sum_en, sum_clr, m_vld, m_last, row_done, busy, err;
    logic [CW-1:0] ex_idx, sum_idx, m_idx;

    always #5 clk = ~clk;

    attn_row_sequencer #(.N_FEAT(N_FEAT), .N_COL(N_COL), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_vld(s_vld), .s_rdy(s_rdy),
        .a_ld(a_ld), .b_ld(b_ld), .mac_en(mac_en), .mac_clr(mac_clr),
        .ex_cap(ex_cap), .ex_idx(ex_idx), .sum_en(sum_en), .sum_clr(sum_clr),
        .sum_idx(sum_idx), .m_vld(m_vld), .m_idx(m_idx), .m_last(m_last),
        .credit_ret(credit_ret), .row_done(row_done), .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [31:0] q_mac[$], q_ex[$], q_sum[$], q_m[$];
    int   n_mac, n_ex, n_sum, n_beat, n_ald, n_bld, n_done, n_gap;
    int   cyc = 0, first_ald, done_cyc, last_beat_cyc;
    logic prev_mvld = 1'b0;
    logic tog_mode, auto_ret, pend_ret;

    always @(posedge clk) cyc++;

    task automatic clear_stats();
        q_mac.delete(); q_ex.delete(); q_sum.delete(); q_m.delete();
        n_mac = 0; n_ex = 0; n_sum = 0; n_beat = 0; n_ald = 0; n_bld = 0;
        n_done = 0; n_gap = 0; first_ald = -1; done_cyc = -1; last_beat_cyc = -10;
    endtask

    task automatic push_row();
        for (int f = 0; f < N_COL * N_FEAT; f++) q_mac.push_back(32'((f % N_FEAT) == 0));
        for (int c = 0; c < N_COL; c++) begin
            q_ex.push_back(32'(c));
            q_sum.push_back((32'(c == 0) << 8) | 32'(c));
            q_m.push_back((32'(c == N_COL - 1) << 8) | 32'(c));
        end
    endtask

    always @(negedge clk) begin
        if (mac_en) begin
            n_mac++;
            if (q_mac.size() == 0) check("mac_unexpected", 1, 0);
            else check("mac_clr", 32'(mac_clr), q_mac.pop_front());
        end
        if (ex_cap) begin
            n_ex++;
            if (q_ex.size() == 0) check("ex_unexpected", 1, 0);
            else check("ex_idx", 32'(ex_idx), q_ex.pop_front());
        end
        if (sum_en) begin
            n_sum++;
            if (q_sum.size() == 0) check("sum_unexpected", 1, 0);
            else check("sum_clr_idx", (32'(sum_clr) << 8) | 32'(sum_idx), q_sum.pop_front());
        end
        if (m_vld) begin
            n_beat++;
            if (n_beat > 1 && cyc != last_beat_cyc + 1) n_gap++;
            last_beat_cyc = cyc;
            if (q_m.size() == 0) check("beat_unexpected", 1, 0);
            else check("m_last_idx", (32'(m_last) << 8) | 32'(m_idx), q_m.pop_front());
        end
        if (a_ld | b_ld | (s_vld & s_rdy)) begin
            check("ld_on_handshake", 32'(a_ld | b_ld), 32'(s_vld & s_rdy));
            check("ld_exclusive", 32'(a_ld & b_ld), 0);
        end
        if (a_ld) begin
            n_ald++;
            if (first_ald < 0) first_ald = cyc;
        end
        if (b_ld) n_bld++;
        if (row_done) begin
            n_done++;
            done_cyc = cyc;
        end
        prev_mvld = m_vld;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog_mode) s_vld = ~s_vld;
        credit_ret = (auto_ret && prev_mvld) || pend_ret;
        pend_ret   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) tick();
        check(tag, 32'(n_done), 1);
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && n_beat < n; i++) tick();
        check(tag, 32'(n_beat), 32'(n));
    endtask

    task automatic check_row_counts(input string tag);
        check({tag, "_mac"},   32'(n_mac),  32'(N_COL * N_FEAT));
        check({tag, "_ex"},    32'(n_ex),   32'(N_COL));
        check({tag, "_sum"},   32'(n_sum),  32'(N_COL));
        check({tag, "_beats"}, 32'(n_beat), 32'(N_COL));
        check({tag, "_a_ld"},  32'(n_ald),  32'(N_COL * N_FEAT));
        check({tag, "_b_ld"},  32'(n_bld),  32'(N_COL * N_FEAT));
        check({tag, "_queues"}, 32'(q_mac.size() + q_ex.size() + q_sum.size() + q_m.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; s_vld = 1'b1; credit_ret = 1'b0;
        tog_mode = 1'b0; auto_ret = 1'b0; pend_ret = 1'b0;
        clear_stats();

        // T1: reset held with en/s_vld asserted
        repeat (3) tick();
        check("t1_s_rdy", 32'(s_rdy), 0);
        check("t1_m_vld", 32'(m_vld), 0);
        check("t1_busy",  32'(busy), 0);
        check("t1_err",   32'(err), 0);
        check("t1_strobes", 32'(a_ld | b_ld | mac_en | ex_cap | sum_en | row_done), 0);
        rst_n = 1'b1;
        check("t1_idle_after_release", 32'({busy, s_rdy}), 0);

        // T2: full row, streaming operands, prompt credit returns
        auto_ret = 1'b1;
        push_row();
        tick();
        check("t2_ld_a_rdy", 32'({busy, s_rdy}), 3);
        en = 1'b0;
        wait_done("t2_row_done", 400);
        check_row_counts("t2");
        check("t2_row_time", 32'(done_cyc - first_ald), 60);
        check("t2_no_beat_gap", 32'(n_gap), 0);
        check("t2_idle", 32'(busy), 0);
        repeat (3) tick();
        check("t2_stays_idle", 32'(busy), 0);

        // T3: input bubbles
        clear_stats();
        tog_mode = 1'b1;
        en = 1'b1;
        push_row();
        tick();
        en = 1'b0;
        wait_done("t3_row_done", 600);
        check_row_counts("t3");
        check("t3_row_slower", 32'(done_cyc - first_ald > 60), 1);
        tog_mode = 1'b0;
        s_vld = 1'b1;

        // T4: credit stall and single-credit release
        do_reset();
        auto_ret = 1'b0;
        en = 1'b1;
        push_row();
        tick();
        en = 1'b0;
        wait_beats("t4_two_beats", 2, 300);
        repeat (6) tick();
        check("t4_stalled_beats", 32'(n_beat), 2);
        check("t4_stalled_vld", 32'({busy, m_vld}), 2);
        pend_ret = 1'b1;
        tick();
        repeat (5) tick();
        check("t4_one_more_beat", 32'(n_beat), 3);
        check("t4_stalled_again", 32'(m_vld), 0);
        pend_ret = 1'b1;
        wait_done("t4_row_done", 50);
        check("t4_all_beats", 32'(n_beat), 4);
        check("t4_err", 32'(err), 0);

        // T5: coincident consume/return, then overflow
        do_reset();
        auto_ret = 1'b1;
        en = 1'b1;
        push_row();
        tick();
        en = 1'b0;
        wait_done("t5_row_done", 400);
        check("t5_back_to_back", 32'(n_gap), 0);
        check("t5_err_clear", 32'(err), 0);
        pend_ret = 1'b1;
        tick();
        tick();
        check("t5_err_set", 32'(err), 1);
        repeat (5) tick();
        check("t5_err_sticky", 32'(err), 1);
        clear_stats();
        auto_ret = 1'b0;
        en = 1'b1;
        push_row();
        tick();
        en = 1'b0;
        wait_beats("t5_sat_beats", 2, 300);
        repeat (6) tick();
        check("t5_saturated", 32'(n_beat), 2);
        check("t5_err_still", 32'(err), 1);

        // T6a: en dropped mid-row
        do_reset();
        check("t6_reset_err", 32'(err), 0);
        auto_ret = 1'b1;
        en = 1'b1;
        push_row();
        tick();
        for (int i = 0; i < 20 && n_mac == 0; i++) tick();
        check("t6_in_mac", 32'(n_mac > 0), 1);
        en = 1'b0;
        wait_done("t6_row_done", 400);
        check("t6_idle", 32'(busy), 0);
        repeat (4) tick();
        check("t6_stays_idle", 32'(busy), 0);
        check("t6_loads", 32'(n_ald), 32'(N_COL * N_FEAT));

        // T6b: drain credits, then reset during SUM of the next row
        clear_stats();
        auto_ret = 1'b0;
        en = 1'b1;
        push_row();
        push_row();
        tick();
        wait_beats("t6_drain", 2, 300);
        pend_ret = 1'b1;
        tick();
        pend_ret = 1'b1;
        tick();
        for (int i = 0; i < 300 && n_sum <= N_COL; i++) tick();
        check("t6_in_sum", 32'({busy, sum_en}), 3);
        rst_n = 1'b0;
        tick();
        check("t6_rst_idle", 32'({busy, sum_en, m_vld, s_rdy}), 0);
        rst_n = 1'b1;
        clear_stats();
        push_row();
        tick();
        en = 1'b0;
        wait_beats("t6_credits_restored", CREDITS, 300);
        repeat (6) tick();
        check("t6_credit_limit", 32'(n_beat), 32'(CREDITS));
        check("t6_err", 32'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
